// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the memory BIST master.
// MEM_BIST_INV_PASS_EN adds a second, inverted-pattern pass.
package mem_bist_pkg;

   localparam int ERR_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      FINISH
   } state_t;

   // Computed at 64 bits; callers truncate to DATA_W (<= 64).
   function automatic logic [63:0] pat(
      input logic [63:0] seed,
      input logic [63:0] addr,
      input logic        inv
   );
      logic [63:0] p;
      p = seed + addr;
      return inv ? ~p : p;
   endfunction

endpackage

// File: rtl/mem_bist_rd_pipe.sv
// Expected-address/valid shift pipeline matching the memory read latency.
// Optional MEM_BIST_INV_PASS_EN lives in the top; this block is unaffected.
module mem_bist_rd_pipe #(
   parameter int DEPTH = 1,
   parameter int W     = 9
) (
   input  logic         clk,
   input  logic         flush,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic [DEPTH-1:0]   vld;
   logic [DEPTH*W-1:0] dat;

   // Shift by concatenating the new entry at the bottom and dropping the top.
   always_ff @(posedge clk) begin
      if (flush) begin
         vld <= '0;
         dat <= '0;
      end else begin
         vld <= DEPTH'({vld, in_valid});
         dat <= (DEPTH*W)'({dat, in_data});
      end
   end

   assign out_valid = vld[DEPTH-1];
   assign out_data  = dat[DEPTH*W-1 -: W];

endmodule

// File: rtl/mem_bist_master.sv
// Memory BIST initiator: write pass, read-back compare, result reporting.
// Define MEM_BIST_INV_PASS_EN to append an inverted-pattern pass.
module mem_bist_master
   import mem_bist_pkg::*;
#(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] seed,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic              Mem_Read,
   output logic              Mem_Write,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] M_W_Data,
   input  logic [DATA_W-1:0] M_R_Data
);

   localparam logic [ADDR_W-1:0] LAST      = '1;
   localparam logic [ADDR_W-1:0] DRAIN_END = ADDR_W'(READ_LATENCY - 1);

   state_t              state;
   logic [ADDR_W-1:0]   cnt;
   logic [DATA_W-1:0]   seed_q;
   logic                inv;

   logic                chk_valid;
   logic                chk_inv;
   logic [ADDR_W-1:0]   chk_addr;
   logic [DATA_W-1:0]   exp_data;
   logic                miss;
   logic [ERR_W-1:0]    err_next;

   // The pipe is fed from the registered strobes so its tail lines up with M_R_Data.
   mem_bist_rd_pipe #(
      .DEPTH (READ_LATENCY),
      .W     (ADDR_W + 1)
   ) u_rd_pipe (
      .clk       (clk),
      .flush     (rst),
      .in_valid  (Mem_Read),
      .in_data   ({inv, Mem_Addr}),
      .out_valid (chk_valid),
      .out_data  ({chk_inv, chk_addr})
   );

   assign exp_data = DATA_W'(pat(64'(seed_q), 64'(chk_addr), chk_inv));
   assign miss     = chk_valid && (M_R_Data != exp_data);
   assign err_next = (miss && err_count != '1) ? err_count + 1'b1 : err_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         seed_q    <= '0;
         inv       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_addr <= '0;
         fail_data <= '0;
         Mem_Read  <= 1'b0;
         Mem_Write <= 1'b0;
         Mem_Addr  <= '0;
         M_W_Data  <= '0;
      end else begin
         err_count <= err_next;
         if (miss && err_count == '0) begin
            fail_addr <= chk_addr;
            fail_data <= M_R_Data;
         end
         done      <= 1'b0;
         Mem_Read  <= 1'b0;
         Mem_Write <= 1'b0;
         Mem_Addr  <= '0;
         M_W_Data  <= '0;
         unique case (state)
            IDLE: begin
               // done still high means this is the finish cycle: ignore start.
               if (start && !done) begin
                  state     <= WRITE;
                  seed_q    <= seed;
                  cnt       <= '0;
                  inv       <= 1'b0;
                  busy      <= 1'b1;
                  pass      <= 1'b0;
                  err_count <= '0;
                  fail_addr <= '0;
                  fail_data <= '0;
               end
            end
            WRITE: begin
               Mem_Write <= 1'b1;
               Mem_Addr  <= cnt;
               M_W_Data  <= DATA_W'(pat(64'(seed_q), 64'(cnt), inv));
               cnt       <= cnt + 1'b1;
               if (cnt == LAST) state <= READ;
            end
            READ: begin
               Mem_Read <= 1'b1;
               Mem_Addr <= cnt;
               cnt      <= cnt + 1'b1;
               if (cnt == LAST) state <= DRAIN;
            end
            DRAIN: begin
               cnt <= cnt + 1'b1;
               if (cnt == DRAIN_END) begin
                  cnt <= '0;
`ifdef MEM_BIST_INV_PASS_EN
                  if (!inv) begin
                     inv   <= 1'b1;
                     state <= WRITE;
                  end else begin
                     state <= FINISH;
                  end
`else
                  state <= FINISH;
`endif
               end
            end
            FINISH: begin
               // The last compare lands on this edge, so judge on err_next.
               done  <= 1'b1;
               busy  <= 1'b0;
               pass  <= (err_next == '0);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
